// File: rtl/mem_sram_ctrl.sv
// Bridges a 32-bit pipeline load/store onto a 16-bit external SRAM as two half-word phases.
// The low half-word is transferred first. Each phase is held for WAIT_CYCLES cycles.
module mem_sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_W_EN,
    input  logic        MEM_R_EN,
    input  logic [31:0] ALU_Res,
    input  logic [31:0] Val_Rm,
    output logic [31:0] out,
    output logic        ready,
    output logic        freeze,
    output logic [17:0] SRAM_ADDR,
    output logic [15:0] SRAM_WDATA,
    input  logic [15:0] SRAM_RDATA,
    output logic        SRAM_WE_N
);
    localparam int unsigned      CNT_W    = 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [31:0]      out_q, out_d;
    logic             wr_q, wr_d;
    logic             req;
    logic             phase_last;
    logic [16:0]      word_idx;

    assign req        = MEM_W_EN | MEM_R_EN;
    assign phase_last = (cnt_q == LAST_CNT);
    // Offset wraps modulo 2^32; only 17 word-index bits reach the SRAM.
    assign word_idx   = 17'((addr_q - BASE_ADDR) >> 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            out_q   <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            out_q   <= out_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        out_d      = out_q;
        wr_d       = wr_q;
        ready      = 1'b0;
        SRAM_ADDR  = '0;
        SRAM_WDATA = '0;
        SRAM_WE_N  = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                ready = ~req;
                if (req) begin
                    // A simultaneous load and store is performed as a store.
                    addr_d  = ALU_Res;
                    data_d  = Val_Rm;
                    wr_d    = MEM_W_EN;
                    cnt_d   = '0;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                SRAM_ADDR  = {word_idx, 1'b0};
                SRAM_WE_N  = ~wr_q;
                SRAM_WDATA = wr_q ? data_q[15:0] : 16'h0000;
                if (phase_last) begin
                    cnt_d   = '0;
                    state_d = S_HIGH;
                    if (!wr_q) begin
                        out_d[15:0] = SRAM_RDATA;
                    end
                end else begin
                    cnt_d = CNT_W'(cnt_q + 4'd1);
                end
            end
            S_HIGH: begin
                SRAM_ADDR  = {word_idx, 1'b1};
                SRAM_WE_N  = ~wr_q;
                SRAM_WDATA = wr_q ? data_q[31:16] : 16'h0000;
                if (phase_last) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    if (!wr_q) begin
                        out_d[31:16] = SRAM_RDATA;
                    end
                end else begin
                    cnt_d = CNT_W'(cnt_q + 4'd1);
                end
            end
            S_DONE: begin
                ready   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign freeze = ~ready;
    assign out    = out_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: directed scenarios plus random load/store traffic compared
// each cycle against a transaction-level model with its own word memory.
module tb_mem_sram_ctrl;
    localparam int unsigned W        = 2;
    localparam int unsigned DONE_POS = 2 * W + 1;
    localparam logic [31:0] BASE     = 32'd1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wen, ren;
    logic [31:0] alu, val;
    logic [31:0] out;
    logic        ready, freeze;
    logic [17:0] addr;
    logic [15:0] wdata, rdata;
    logic        we_n;

    logic        b_ren;
    logic [31:0] b_alu;
    logic [31:0] b_out;
    logic        b_ready, b_freeze;
    logic [17:0] b_addr;
    logic [15:0] b_wdata, b_rdata;
    logic        b_we_n;

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    logic [15:0] sram      [0:262143];
    logic [31:0] model_mem [0:131071];

    int unsigned m_pos = 0;
    logic        m_wr  = 1'b0;
    logic [16:0] m_idx = '0;
    logic [31:0] m_data = '0;
    logic [31:0] m_out  = '0;

    always #5 clk = ~clk;

    mem_sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .MEM_W_EN(wen), .MEM_R_EN(ren),
        .ALU_Res(alu), .Val_Rm(val), .out(out), .ready(ready), .freeze(freeze),
        .SRAM_ADDR(addr), .SRAM_WDATA(wdata), .SRAM_RDATA(rdata), .SRAM_WE_N(we_n)
    );

    mem_sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(BASE)) dut_w1 (
        .clk(clk), .rst(rst), .MEM_W_EN(1'b0), .MEM_R_EN(b_ren),
        .ALU_Res(b_alu), .Val_Rm(32'h0), .out(b_out), .ready(b_ready), .freeze(b_freeze),
        .SRAM_ADDR(b_addr), .SRAM_WDATA(b_wdata), .SRAM_RDATA(b_rdata), .SRAM_WE_N(b_we_n)
    );

    // External SRAM: combinational read while not writing, write on the clock edge.
    assign rdata   = we_n ? sram[addr] : 16'h0000;
    assign b_rdata = b_addr[0] ? 16'hBBBB : 16'hAAAA;
    always @(posedge clk) if (!we_n) sram[addr] <= wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        wen = w;
        ren = r;
        alu = a;
        val = d;
    endtask

    // Transaction model: m_pos counts cycles into the access (0 = idle, DONE_POS = completion).
    always @(posedge clk or posedge rst) begin : model_p
        logic [16:0] idx;
        if (rst) begin
            m_pos <= 0;
            m_out <= '0;
        end else if (m_pos == 0) begin
            if (wen || ren) begin
                idx    = 17'((alu - BASE) >> 2);
                m_pos  <= 1;
                m_wr   <= wen;
                m_idx  <= idx;
                if (wen) begin
                    m_data         <= val;
                    model_mem[idx] <= val;
                end else begin
                    m_data <= model_mem[idx];
                end
            end
        end else if (m_pos == DONE_POS) begin
            m_pos <= 0;
        end else begin
            if (m_pos == 2 * W && !m_wr) m_out <= m_data;
            m_pos <= m_pos + 1;
        end
    end

    always @(negedge clk) begin : cmp_p
        logic        lo, hi, e_rdy;
        logic [17:0] e_addr;
        logic [15:0] e_wd;
        if (chk_en && !rst) begin
            lo     = (m_pos >= 1) && (m_pos <= W);
            hi     = (m_pos > W) && (m_pos <= 2 * W);
            e_rdy  = (m_pos == 0) ? !(wen || ren) : (m_pos == DONE_POS);
            e_addr = lo ? {m_idx, 1'b0} : (hi ? {m_idx, 1'b1} : 18'h0);
            e_wd   = (m_wr && lo) ? m_data[15:0] : ((m_wr && hi) ? m_data[31:16] : 16'h0);
            chk("m_ready",  32'(ready),  32'(e_rdy));
            chk("m_freeze", 32'(freeze), 32'(!e_rdy));
            chk("m_addr",   32'(addr),   32'(e_addr));
            chk("m_we_n",   32'(we_n),   32'(!(m_wr && (lo || hi))));
            chk("m_wdata",  32'(wdata),  32'(e_wd));
            if (m_pos == 0 || m_pos == DONE_POS) chk("m_out", out, m_out);
        end
    end

    initial begin
        for (int i = 0; i < 262144; i++) sram[i] = 16'h0000;
        for (int i = 0; i < 131072; i++) model_mem[i] = 32'h0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        b_ren = 1'b0;
        b_alu = 32'h0;

        // Reset state, including ready following live request inputs.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",  32'(ready),  32'd1);
        chk("rst_freeze", 32'(freeze), 32'd0);
        chk("rst_we_n",   32'(we_n),   32'd1);
        chk("rst_addr",   32'(addr),   32'd0);
        chk("rst_wdata",  32'(wdata),  32'd0);
        chk("rst_out",    out,         32'd0);
        wen = 1'b1;
        #1 chk("rst_ready_req", 32'(ready), 32'd0);
        wen = 1'b0;

        // WAIT_CYCLES=1 back-to-back reads held asserted.
        @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        b_ren  = 1'b1;
        b_alu  = BASE + 32'd8;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("w1_ready",  32'(b_ready),  32'((i == 3 || i == 7) ? 1 : 0));
            chk("w1_freeze", 32'(b_freeze), 32'((i == 3 || i == 7) ? 0 : 1));
            chk("w1_we_n",   32'(b_we_n),   32'd1);
            chk("w1_wdata",  32'(b_wdata),  32'd0);
            if (i == 1) chk("w1_addr_lo", 32'(b_addr), 32'd4);
            if (i == 2) chk("w1_addr_hi", 32'(b_addr), 32'd5);
            if (i == 3) chk("w1_out", b_out, 32'hBBBBAAAA);
            @(posedge clk);
        end
        #1 b_ren = 1'b0;

        // Write DEADBEEF at BASE; inputs scrambled once the access is latched.
        drive(1'b1, 1'b0, BASE, 32'hDEADBEEF);
        #1 chk("w_req_ready", 32'(ready), 32'd0);
        cyc(1);
        chk("w_lo_addr",  32'(addr),  32'd0);
        chk("w_lo_wdata", 32'(wdata), 32'hBEEF);
        chk("w_lo_we_n",  32'(we_n),  32'd0);
        drive(1'b0, 1'b0, $urandom, $urandom);
        cyc(1);
        chk("w_lo2_we_n", 32'(we_n), 32'd0);
        cyc(1);
        chk("w_hi_addr",  32'(addr),  32'd1);
        chk("w_hi_wdata", 32'(wdata), 32'hDEAD);
        cyc(1);
        chk("w_c4_ready", 32'(ready), 32'd0);
        cyc(1);
        chk("w_c5_ready",  32'(ready),  32'd1);
        chk("w_c5_freeze", 32'(freeze), 32'd0);
        cyc(1);

        // Read-back of the same word.
        drive(1'b0, 1'b1, BASE, 32'h0);
        cyc(1);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("r_we_n", 32'(we_n), 32'd1);
        cyc(4);
        chk("r_done_ready", 32'(ready), 32'd1);
        chk("r_done_out",   out,        32'hDEADBEEF);
        cyc(3);
        chk("r_held_out", out, 32'hDEADBEEF);

        // Address below BASE wraps to the top of the SRAM.
        drive(1'b1, 1'b0, 32'd1020, 32'hCAFEF00D);
        cyc(1);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("wrap_lo_addr", 32'(addr), 32'h3FFFE);
        cyc(2);
        chk("wrap_hi_addr", 32'(addr), 32'h3FFFF);
        cyc(3);

        // Load and store together act as a store.
        drive(1'b1, 1'b1, BASE + 32'd4, 32'h11223344);
        cyc(1);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("sim_we_n",  32'(we_n),  32'd0);
        chk("sim_wdata", 32'(wdata), 32'h3344);
        cyc(4);
        chk("sim_out", out, 32'hDEADBEEF);
        cyc(1);

        // Asynchronous reset in the second HIGH cycle of a write.
        drive(1'b1, 1'b0, BASE + 32'd400, 32'h55AA55AA);
        cyc(1);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        cyc(3);
        chk("ar_pre_we_n", 32'(we_n), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("ar_we_n",  32'(we_n),  32'd1);
        chk("ar_addr",  32'(addr),  32'd0);
        chk("ar_wdata", 32'(wdata), 32'd0);
        chk("ar_ready", 32'(ready), 32'd1);
        chk("ar_out",   out,        32'd0);
        #1 rst = 1'b0;
        cyc(1);
        drive(1'b0, 1'b1, BASE, 32'h0);
        cyc(1);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        cyc(4);
        chk("ar_next_ready", 32'(ready), 32'd1);
        chk("ar_next_out",   out,        32'hDEADBEEF);
        cyc(1);

        // Random traffic; inputs change every cycle, including mid-access.
        for (int n = 0; n < 1500; n++) begin
            int unsigned k;
            logic [31:0] a;
            k = $urandom_range(0, 11);
            a = (k < 8) ? BASE + 32'(4 * k) : BASE - 32'(4 * (k - 7));
            a = a + 32'($urandom_range(0, 3));
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), a, $urandom);
            cyc(1);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        cyc(DONE_POS + 2);
        chk_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
